// File: rtl/alu_seq_pkg.sv
// Shared types and sizes for the ALU operation sequencer.
//   DATA_W      : operand/result width
//   NREGS, RA_W : register-file depth and address width
//   alu_op_e    : ALU select codes
//   seq_state_e : sequencer FSM states
//   cmd_t       : one command as presented on the cmd_* inputs
package alu_seq_pkg;
  localparam int DATA_W = 8;
  localparam int NREGS  = 4;
  localparam int RA_W   = $clog2(NREGS);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOR = 3'd5,
    OP_SHL = 3'd6,
    OP_GT  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic              ld;
    alu_op_e           op;
    logic [RA_W-1:0]   rd;
    logic [RA_W-1:0]   rs1;
    logic [RA_W-1:0]   rs2;
    logic              imm_en;
    logic [DATA_W-1:0] imm;
  } cmd_t;
endpackage

// File: rtl/alu_seq_regfile.sv
// Operand register file: NREGS x DATA_W, two asynchronous read ports,
// one synchronous write port, asynchronous active-low clear to zero.
//   clk, rst_n         : clock, async active-low clear
//   we, waddr, wdata   : write port (takes effect on rising edge)
//   raddr_a, rdata_a   : read port A (combinational)
//   raddr_b, rdata_b   : read port B (combinational)
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [RA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RA_W-1:0]   raddr_a,
  input  logic [RA_W-1:0]   raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);
  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
endmodule

// File: rtl/alu_op_sequencer.sv
// Command-driven front end for an external combinational ALU.
// Accepts commands over cmd_valid/cmd_ready, reads operands from a
// 4-entry register file, drives the ALU for one ISSUE cycle, writes the
// result back and returns result + flags over rsp_valid/rsp_ready.
//   clk, rst_n                 : clock, async active-low reset
//   cmd_valid/cmd_ready        : command handshake
//   cmd_ld, cmd_op, cmd_rd,
//   cmd_rs1, cmd_rs2,
//   cmd_imm_en, cmd_imm        : command payload
//   alu_a, alu_b, alu_sel      : registered ALU inputs
//   alu_out, alu_zero, alu_carry : ALU results
//   rsp_valid/rsp_ready        : response handshake
//   rsp_data, rsp_zero,
//   rsp_carry, rsp_rd          : response payload
//   busy                       : high whenever not IDLE
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_ld,
  input  logic [2:0]        cmd_op,
  input  logic [RA_W-1:0]   cmd_rd,
  input  logic [RA_W-1:0]   cmd_rs1,
  input  logic [RA_W-1:0]   cmd_rs2,
  input  logic              cmd_imm_en,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_carry,
  output logic [RA_W-1:0]   rsp_rd,
  output logic              busy
);
  seq_state_e        state, state_d;
  cmd_t              cmd;
  logic              accept;
  logic [RA_W-1:0]   rd_q;
  logic              rf_we;
  logic [RA_W-1:0]   rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rdata_a, rdata_b;

  always_comb begin
    cmd = '{ld: cmd_ld, op: alu_op_e'(cmd_op), rd: cmd_rd, rs1: cmd_rs1,
            rs2: cmd_rs2, imm_en: cmd_imm_en, imm: cmd_imm};
  end

  // Single write port shared by the load path (in IDLE) and the ALU
  // write-back (in ISSUE); the two never coincide.
  always_comb begin
    rf_we    = (accept && cmd.ld) || (state == ISSUE);
    rf_waddr = (state == ISSUE) ? rd_q : cmd.rd;
    rf_wdata = (state == ISSUE) ? alu_out : cmd.imm;
  end

  alu_seq_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (cmd.rs1),
    .raddr_b (cmd.rs2),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = cmd.ld ? RESP : ISSUE;
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands are sampled on the accept edge so the ALU inputs stay flat
  // through ISSUE; the result is captured at the end of ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_q      <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_carry <= 1'b0;
      rsp_rd    <= '0;
    end else begin
      state <= state_d;
      if (accept && !cmd.ld) begin
        alu_a   <= rdata_a;
        alu_b   <= cmd.imm_en ? cmd.imm : rdata_b;
        alu_sel <= cmd.op;
        rd_q    <= cmd.rd;
      end
      if (accept && cmd.ld) begin
        rsp_data  <= cmd.imm;
        rsp_zero  <= (cmd.imm == '0);
        rsp_carry <= 1'b0;
        rsp_rd    <= cmd.rd;
      end
      if (state == ISSUE) begin
        rsp_data  <= alu_out;
        rsp_zero  <= alu_zero;
        rsp_carry <= alu_carry;
        rsp_rd    <= rd_q;
      end
    end
  end

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              zero;
    logic              carry;
    logic [RA_W-1:0]   rd;
  } rsp_t;

  typedef struct {
    int          lat;
    rsp_t        rsp;
    logic [18:0] alu;
  } obs_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_ld = 1'b0;
  logic [2:0]        cmd_op = '0;
  logic [RA_W-1:0]   cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic              cmd_imm_en = 1'b0;
  logic [DATA_W-1:0] cmd_imm = '0;
  logic [DATA_W-1:0] alu_a, alu_b, alu_out;
  logic [2:0]        alu_sel;
  logic              alu_zero, alu_carry;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_zero, rsp_carry;
  logic [RA_W-1:0]   rsp_rd;
  logic              busy;

  int passed = 0;
  int total  = 0;

  logic [DATA_W-1:0] mr [NREGS];
  logic [18:0]       exp_alu;
  rsp_t              exp_q[$];
  rsp_t              got_q[$];
  int                acc_q[$];
  int                cyc = 0;
  logic              mon_en = 1'b0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ld(cmd_ld),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_rd(rsp_rd), .busy(busy)
  );

  // Reference ALU: {result, zero, carry}
  function automatic logic [9:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] sel);
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    s = '0; r = '0; c = 1'b0;
    case (sel)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~(a | b);
      3'd6: r = a << 1;
      default: r = (a > b) ? 8'd1 : 8'd0;
    endcase
    return {r, (r == 8'd0), c};
  endfunction

  always_comb {alu_out, alu_zero, alu_carry} = alu_fn(alu_a, alu_b, alu_sel);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mon_en && cmd_valid && cmd_ready) acc_q.push_back(cyc);
    if (mon_en && rsp_valid && rsp_ready) got_q.push_back({rsp_data, rsp_zero, rsp_carry, rsp_rd});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic cmd_t mk(input logic ld, input alu_op_e op, input logic [1:0] rd,
                              input logic [1:0] rs1, input logic [1:0] rs2,
                              input logic ie, input logic [7:0] imm);
    cmd_t c;
    c.ld = ld; c.op = op; c.rd = rd; c.rs1 = rs1; c.rs2 = rs2; c.imm_en = ie; c.imm = imm;
    return c;
  endfunction

  // Scoreboard model: returns the expected response and updates model regs.
  function automatic rsp_t predict(input cmd_t c);
    logic [7:0] a, b;
    logic [9:0] m;
    rsp_t r;
    if (c.ld) begin
      mr[c.rd] = c.imm;
      r = {c.imm, (c.imm == 8'd0), 1'b0, c.rd};
    end else begin
      a = mr[c.rs1];
      b = c.imm_en ? c.imm : mr[c.rs2];
      m = alu_fn(a, b, c.op);
      exp_alu = {a, b, c.op};
      mr[c.rd] = m[9:2];
      r = {m[9:2], m[1], m[0], c.rd};
    end
    return r;
  endfunction

  task automatic drive(input cmd_t c);
    cmd_ld = c.ld; cmd_op = c.op; cmd_rd = c.rd; cmd_rs1 = c.rs1;
    cmd_rs2 = c.rs2; cmd_imm_en = c.imm_en; cmd_imm = c.imm;
  endtask

  // Drives one command, returns latency, ALU inputs seen in the cycle after
  // accept, and the response payload. Consumes the response if rsp_ready=1.
  task automatic issue(input cmd_t c, output obs_t o);
    int n;
    drive(c);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    o.alu = {alu_a, alu_b, alu_sel};
    o.lat = 1;
    while (!rsp_valid && o.lat < 20) begin @(posedge clk); #1; o.lat++; end
    o.rsp = {rsp_data, rsp_zero, rsp_carry, rsp_rd};
    if (rsp_ready && rsp_valid) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL reset_ctl valid/busy got %b want 00", {rsp_valid, busy}); else passed++;
    total++; if ({alu_a, alu_b, alu_sel} !== 19'd0) $display("FAIL reset_alu got %h want 0", {alu_a, alu_b, alu_sel}); else passed++;
    total++; if ({rsp_data, rsp_zero, rsp_carry, rsp_rd} !== 12'd0) $display("FAIL reset_rsp got %h want 0", {rsp_data, rsp_zero, rsp_carry, rsp_rd}); else passed++;
    rst_n = 1'b1;
    for (int i = 0; i < NREGS; i++) mr[i] = '0;
    @(posedge clk); #1;
    total++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", cmd_ready); else passed++;
  endtask

  task automatic test_load();
    obs_t o; rsp_t e; cmd_t c;
    c = mk(1, OP_ADD, 0, 0, 0, 0, 8'd200); exp_q.push_back(predict(c)); issue(c, o); e = exp_q.pop_front();
    total++; if (o.rsp !== e) $display("FAIL ld_r0 rsp got %h want %h", o.rsp, e); else passed++;
    total++; if (o.lat !== 1) $display("FAIL ld_r0 latency got %0d want 1", o.lat); else passed++;
    total++; if (o.rsp.data !== 8'd200 || o.rsp.zero !== 1'b0 || o.rsp.carry !== 1'b0) $display("FAIL ld_r0 data got %0d want 200", o.rsp.data); else passed++;
    c = mk(1, OP_ADD, 1, 0, 0, 0, 8'd100); exp_q.push_back(predict(c)); issue(c, o); e = exp_q.pop_front();
    total++; if (o.rsp !== e) $display("FAIL ld_r1 rsp got %h want %h", o.rsp, e); else passed++;
    total++; if (o.lat !== 1) $display("FAIL ld_r1 latency got %0d want 1", o.lat); else passed++;
  endtask

  task automatic test_add();
    obs_t o; rsp_t e; cmd_t c;
    c = mk(0, OP_ADD, 2, 0, 1, 0, 8'd0); exp_q.push_back(predict(c)); issue(c, o); e = exp_q.pop_front();
    total++; if (o.alu !== {8'd200, 8'd100, 3'd0}) $display("FAIL add_alu_in got %h want %h", o.alu, {8'd200, 8'd100, 3'd0}); else passed++;
    total++; if (o.rsp !== e) $display("FAIL add rsp got %h want %h", o.rsp, e); else passed++;
    total++; if ({o.rsp.data, o.rsp.carry, o.rsp.zero} !== {8'd44, 1'b1, 1'b0}) $display("FAIL add_const got %0d/c%b want 44/c1", o.rsp.data, o.rsp.carry); else passed++;
    total++; if (o.lat !== 2) $display("FAIL add latency got %0d want 2", o.lat); else passed++;
    c = mk(0, OP_OR, 2, 2, 0, 1, 8'd0); exp_q.push_back(predict(c)); issue(c, o); e = exp_q.pop_front();
    total++; if (o.rsp !== e || o.rsp.data !== 8'd44) $display("FAIL r2_readback got %h want %h", o.rsp, e); else passed++;
  endtask

  task automatic test_logic();
    obs_t o; rsp_t e; cmd_t c;
    c = mk(0, OP_XOR, 3, 0, 0, 0, 8'd0); exp_q.push_back(predict(c)); issue(c, o); e = exp_q.pop_front();
    total++; if (o.rsp !== e || o.rsp.zero !== 1'b1) $display("FAIL xor got %h want %h", o.rsp, e); else passed++;
    c = mk(0, OP_SUB, 3, 0, 1, 0, 8'd0); exp_q.push_back(predict(c)); issue(c, o); e = exp_q.pop_front();
    total++; if (o.rsp !== e || o.rsp.data !== 8'd100) $display("FAIL sub got %h want %h", o.rsp, e); else passed++;
    c = mk(0, OP_SHL, 3, 1, 0, 1, 8'd0); exp_q.push_back(predict(c)); issue(c, o); e = exp_q.pop_front();
    total++; if (o.alu !== exp_alu || o.alu[18:11] !== 8'd100) $display("FAIL shl_alu_in got %h want %h", o.alu, exp_alu); else passed++;
    total++; if (o.rsp !== e || o.rsp.data !== 8'd200) $display("FAIL shl got %h want %h", o.rsp, e); else passed++;
    c = mk(0, OP_GT, 3, 0, 1, 0, 8'd0); exp_q.push_back(predict(c)); issue(c, o); e = exp_q.pop_front();
    total++; if (o.rsp !== e || o.rsp.data !== 8'd1) $display("FAIL gt got %h want %h", o.rsp, e); else passed++;
    c = mk(0, OP_NOR, 3, 1, 0, 1, 8'h0F); exp_q.push_back(predict(c)); issue(c, o); e = exp_q.pop_front();
    total++; if (o.rsp !== e) $display("FAIL nor got %h want %h", o.rsp, e); else passed++;
    c = mk(0, OP_AND, 3, 0, 1, 0, 8'd0); exp_q.push_back(predict(c)); issue(c, o); e = exp_q.pop_front();
    total++; if (o.rsp !== e) $display("FAIL and got %h want %h", o.rsp, e); else passed++;
  endtask

  task automatic test_back_pressure();
    obs_t o; rsp_t e; cmd_t c; rsp_t snap; rsp_t now;
    rsp_ready = 1'b0;
    c = mk(0, OP_ADD, 2, 0, 1, 0, 8'd0); exp_q.push_back(predict(c)); issue(c, o); e = exp_q.pop_front();
    total++; if (o.rsp !== e) $display("FAIL bp_add rsp got %h want %h", o.rsp, e); else passed++;
    snap = o.rsp;
    c = mk(1, OP_ADD, 3, 0, 0, 0, 8'd7);
    drive(c);
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      now = {rsp_data, rsp_zero, rsp_carry, rsp_rd};
      total++;
      if ({rsp_valid, busy, cmd_ready, now, alu_a, alu_b, alu_sel} !== {3'b110, snap, o.alu})
        $display("FAIL bp_hold cyc%0d got v%b b%b r%b %h want v1 b1 r0 %h", i, rsp_valid, busy, cmd_ready, now, snap);
      else passed++;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    total++; if ({cmd_ready, rsp_valid} !== 2'b10) $display("FAIL bp_release got rdy%b v%b want rdy1 v0", cmd_ready, rsp_valid); else passed++;
    exp_q.push_back(predict(c));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    e = exp_q.pop_front();
    now = {rsp_data, rsp_zero, rsp_carry, rsp_rd};
    total++; if (rsp_valid !== 1'b1 || now !== e) $display("FAIL bp_pending got v%b %h want v1 %h", rsp_valid, now, e); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    obs_t o; rsp_t e; cmd_t c;
    c = mk(0, OP_ADD, 2, 0, 1, 0, 8'd0);
    drive(c);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL rm_in_issue busy got %b want 1", busy); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if ({rsp_valid, busy, cmd_ready} !== 3'b001) $display("FAIL rm_async got v%b b%b r%b want v0 b0 r1", rsp_valid, busy, cmd_ready); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < NREGS; i++) mr[i] = '0;
    @(posedge clk); #1;
    c = mk(1, OP_ADD, 3, 0, 0, 0, 8'h5A); exp_q.push_back(predict(c)); issue(c, o); e = exp_q.pop_front();
    total++; if (o.rsp !== e) $display("FAIL rm_load got %h want %h", o.rsp, e); else passed++;
    c = mk(0, OP_OR, 0, 2, 0, 1, 8'd0); exp_q.push_back(predict(c)); issue(c, o); e = exp_q.pop_front();
    total++; if (o.rsp !== e || o.rsp.data !== 8'd0 || o.rsp.zero !== 1'b1) $display("FAIL rm_cleared got %h want %h", o.rsp, e); else passed++;
  endtask

  task automatic test_back_to_back();
    cmd_t seq [4];
    rsp_t e, g;
    int n;
    seq[0] = mk(1, OP_ADD, 0, 0, 0, 0, 8'd10);
    seq[1] = mk(1, OP_ADD, 1, 0, 0, 0, 8'd20);
    seq[2] = mk(0, OP_ADD, 2, 0, 1, 0, 8'd0);
    seq[3] = mk(0, OP_XOR, 3, 2, 0, 1, 8'hFF);
    rsp_ready = 1'b1;
    acc_q.delete(); got_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(predict(seq[i]));
      drive(seq[i]);
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    n = 0;
    while (got_q.size() < 4 && n < 50) begin @(posedge clk); #1; n++; end
    mon_en = 1'b0;
    total++; if (acc_q.size() !== 4) $display("FAIL b2b_accepts got %0d want 4", acc_q.size()); else passed++;
    total++; if (acc_q[1] - acc_q[0] !== 2) $display("FAIL b2b_ld_gap got %0d want 2", acc_q[1] - acc_q[0]); else passed++;
    total++; if (acc_q[2] - acc_q[1] !== 2) $display("FAIL b2b_ld_gap2 got %0d want 2", acc_q[2] - acc_q[1]); else passed++;
    total++; if (acc_q[3] - acc_q[2] !== 3) $display("FAIL b2b_alu_gap got %0d want 3", acc_q[3] - acc_q[2]); else passed++;
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      total++; if (g !== e) $display("FAIL b2b_rsp%0d got %h want %h", i, g, e); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_add();
    test_logic();
    test_back_pressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
